// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared alarm-clock constants and sequencer state encodings
package aclk_pkg;

  localparam int TIME_W  = 16;
  localparam int STATE_W = 3;

  // Keypad "no key pressed" code, also decoded by aclk_controller.
  localparam logic [3:0] NO_KEY = 4'b1010;

  localparam logic [STATE_W-1:0] ST_DISARMED = 3'd0;
  localparam logic [STATE_W-1:0] ST_ARMED    = 3'd1;
  localparam logic [STATE_W-1:0] ST_RINGING  = 3'd2;
  localparam logic [STATE_W-1:0] ST_SNOOZE   = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/aclk_sec_timer.sv
// rtl/aclk_sec_timer.sv - loadable seconds down-counter with zero and expire flags
module aclk_sec_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         one_second,
  output logic         zero,
  output logic         expire
);

  logic [W-1:0] count;

  // Load wins over a coincident tick, so a freshly loaded value is never shortened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (one_second && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero   = (count == '0);
  assign expire = one_second && (count == W'(1));

endmodule

// File: rtl/aclk_alarm_sequencer.sv
// rtl/aclk_alarm_sequencer.sv - alarm-event sequencer: ring window, snooze limit,
// manual stop and same-minute re-trigger lockout
module aclk_alarm_sequencer
  import aclk_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               one_second,
  input  logic [TIME_W-1:0]                  current_time,
  input  logic [TIME_W-1:0]                  alarm_time,
  input  logic                               alarm_enable,
  input  logic                               snooze_button,
  input  logic                               stop_button,
  output logic                               sound,
  output logic                               ringing,
  output logic                               snoozing,
  output logic [$clog2(MAX_SNOOZES+1)-1:0]   snoozes_used
);

  localparam int SU_W  = $clog2(MAX_SNOOZES + 1);
  localparam int T_MAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int TW    = $clog2(T_MAX + 1);

  logic [STATE_W-1:0] state, state_next;
  logic               snooze_q, stop_q;
  logic               snz_rise, stp_rise, match;
  logic               beep_phase, beep_next;
  logic [SU_W-1:0]    su_next;
  logic               ring_load, snz_load, tmr_clear;
  logic               ring_zero, ring_expire, snz_zero, snz_expire;
  logic               sound_d, ringing_d, snoozing_d;

  assign match    = (current_time == alarm_time);
  assign snz_rise = snooze_button & ~snooze_q;
  assign stp_rise = stop_button & ~stop_q;

  aclk_sec_timer #(.W(TW)) u_ring_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (tmr_clear),
    .load       (ring_load),
    .value      (TW'(RING_TIMEOUT_S)),
    .one_second (one_second),
    .zero       (ring_zero),
    .expire     (ring_expire)
  );

  aclk_sec_timer #(.W(TW)) u_snooze_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (tmr_clear),
    .load       (snz_load),
    .value      (TW'(SNOOZE_S)),
    .one_second (one_second),
    .zero       (snz_zero),
    .expire     (snz_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_DISARMED;
      snooze_q     <= 1'b0;
      stop_q       <= 1'b0;
      beep_phase   <= 1'b0;
      snoozes_used <= '0;
      sound        <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      state        <= state_next;
      snooze_q     <= snooze_button;
      stop_q       <= stop_button;
      beep_phase   <= beep_next;
      snoozes_used <= su_next;
      sound        <= sound_d;
      ringing      <= ringing_d;
      snoozing     <= snoozing_d;
    end
  end

  // Branch order encodes priority: disable > stop > snooze > expiry > plain tick.
  always_comb begin
    state_next = state;
    su_next    = snoozes_used;
    beep_next  = beep_phase;
    ring_load  = 1'b0;
    snz_load   = 1'b0;
    tmr_clear  = 1'b0;
    if (!alarm_enable) begin
      state_next = ST_DISARMED;
      su_next    = '0;
      beep_next  = 1'b0;
      tmr_clear  = 1'b1;
    end else begin
      case (state)
        ST_DISARMED: state_next = ST_ARMED;
        ST_ARMED: begin
          if (match) begin
            state_next = ST_RINGING;
            ring_load  = 1'b1;
            beep_next  = 1'b1;
          end
        end
        ST_RINGING: begin
          if (stp_rise) begin
            state_next = ST_DONE;
          end else if (snz_rise && (snoozes_used < SU_W'(MAX_SNOOZES))) begin
            state_next = ST_SNOOZE;
            snz_load   = 1'b1;
            su_next    = snoozes_used + SU_W'(1);
          end else if (ring_expire || ring_zero) begin
            state_next = ST_DONE;
          end else if (one_second) begin
            beep_next = ~beep_phase;
          end
        end
        ST_SNOOZE: begin
          if (stp_rise) begin
            state_next = ST_DONE;
          end else if (snz_expire || snz_zero) begin
            state_next = ST_RINGING;
            ring_load  = 1'b1;
            beep_next  = 1'b1;
          end
        end
        ST_DONE: begin
          // Hold until the matching minute has passed to prevent a re-trigger.
          if (!match) state_next = ST_ARMED;
        end
        default: state_next = ST_DISARMED;
      endcase
      if (state_next == ST_DONE) begin
        su_next   = '0;
        tmr_clear = 1'b1;
      end
    end
  end

  always_comb begin
    ringing_d  = (state_next == ST_RINGING);
    snoozing_d = (state_next == ST_SNOOZE);
    sound_d    = ringing_d & beep_next;
  end

endmodule
